// File: rtl/threshold_pkg.sv
`default_nettype none
// threshold_pkg: mode encoding, luma coefficients and FSM state encoding
// shared by the pixel threshold stream blocks.
package threshold_pkg;

  localparam logic [1:0] MODE_BINARY   = 2'd0;
  localparam logic [1:0] MODE_INVERTED = 2'd1;
  localparam logic [1:0] MODE_TO_ZERO  = 2'd2;
  localparam logic [1:0] MODE_TRUNC    = 2'd3;

  // BT.601-style weights scaled by 256; they sum to exactly 256
  localparam int unsigned LUMA_COEF_R = 77;
  localparam int unsigned LUMA_COEF_G = 150;
  localparam int unsigned LUMA_COEF_B = 29;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/luma_calc.sv
`default_nettype none
// luma_calc: one registered stage computing pixel luma and carrying the
// original pixel alongside it.
module luma_calc
  import threshold_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int CHANNELS = 3
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      en,
  input  logic                      in_valid,
  input  logic [CHANNELS*PIX_W-1:0] in_data,
  output logic                      out_valid,
  output logic [PIX_W-1:0]          luma,
  output logic [CHANNELS*PIX_W-1:0] out_data
);

  logic [PIX_W-1:0] luma_next;

  generate
    if (CHANNELS == 3) begin : g_rgb
      logic [PIX_W+7:0] r, g, b, sum;
      assign r   = (PIX_W+8)'(in_data[PIX_W-1:0]);
      assign g   = (PIX_W+8)'(in_data[2*PIX_W-1:PIX_W]);
      assign b   = (PIX_W+8)'(in_data[3*PIX_W-1:2*PIX_W]);
      // Weights sum to 256, so the sum fits PIX_W+8 bits and >>8 stays in range
      assign sum = r * (PIX_W+8)'(LUMA_COEF_R)
                 + g * (PIX_W+8)'(LUMA_COEF_G)
                 + b * (PIX_W+8)'(LUMA_COEF_B);
      assign luma_next = sum[PIX_W+7:8];
    end else begin : g_mono
      assign luma_next = in_data[PIX_W-1:0];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!RST) begin
      out_valid <= 1'b0;
      luma      <= '0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      luma      <= luma_next;
      out_data  <= in_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pixel_threshold_stream.sv
`default_nettype none
// pixel_threshold_stream: framed pixel stream thresholded on luma (luma, decision stages).
// Define THRESH_HYST_EN for per-row hysteresis in BINARY/INVERTED modes.
module pixel_threshold_stream
  import threshold_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int CHANNELS = 3,
  parameter int COLS     = 256,
  parameter int ROWS     = 256
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      start,
  input  logic [1:0]                cfg_mode,
  input  logic [PIX_W-1:0]          cfg_thresh,
  input  logic [PIX_W-1:0]          cfg_thresh_lo,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [CHANNELS*PIX_W-1:0] s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [CHANNELS*PIX_W-1:0] m_data,
  output logic                      m_sof,
  output logic                      m_eol,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int DW    = CHANNELS * PIX_W;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [DW-1:0] ONES = {DW{1'b1}};

  state_t             state;
  logic [1:0]         mode_q;
  logic [PIX_W-1:0]   thresh_q, thresh_lo_q;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               adv, in_fire, last_col, last_row;
  logic               s1_valid, s1_sof, s1_eol, s1_first_col;
  logic [PIX_W-1:0]   s1_luma;
  logic [DW-1:0]      s1_data, dec_data;
  logic               hit_strict, hit;

  // A bubble at the output may always be filled; a held output freezes everything
  assign adv      = m_ready || !m_valid;
  assign s_ready  = (state == ST_RUN) && adv;
  assign in_fire  = s_valid && s_ready;
  assign last_col = (col == COL_W'(COLS - 1));
  assign last_row = (row == ROW_W'(ROWS - 1));
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= ST_IDLE;
      mode_q      <= MODE_BINARY;
      thresh_q    <= '0;
      thresh_lo_q <= '0;
      col         <= '0;
      row         <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          state       <= ST_RUN;
          mode_q      <= cfg_mode;
          thresh_q    <= cfg_thresh;
          thresh_lo_q <= cfg_thresh_lo;
          col         <= '0;
          row         <= '0;
        end
        ST_RUN: if (in_fire) begin
          if (last_col) begin
            col <= '0;
            if (last_row) begin
              row   <= '0;
              state <= ST_FLUSH;
            end else begin
              row <= row + ROW_W'(1);
            end
          end else begin
            col <= col + COL_W'(1);
          end
        end
        ST_FLUSH: if (!s1_valid && (!m_valid || m_ready)) begin
          state      <= ST_IDLE;
          frame_done <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  luma_calc #(
    .PIX_W    (PIX_W),
    .CHANNELS (CHANNELS)
  ) u_luma (
    .CLK       (CLK),
    .RST       (RST),
    .en        (adv),
    .in_valid  (in_fire),
    .in_data   (s_data),
    .out_valid (s1_valid),
    .luma      (s1_luma),
    .out_data  (s1_data)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      s1_sof       <= 1'b0;
      s1_eol       <= 1'b0;
      s1_first_col <= 1'b0;
    end else if (adv) begin
      s1_sof       <= (col == '0) && (row == '0);
      s1_eol       <= last_col;
      s1_first_col <= (col == '0);
    end
  end

  assign hit_strict = (s1_luma > thresh_q);

`ifdef THRESH_HYST_EN
  logic hyst_q, hyst_next;

  always_comb begin
    hyst_next = s1_first_col ? 1'b0 : hyst_q;
    if (hit_strict)
      hyst_next = 1'b1;
    else if (s1_luma < thresh_lo_q)
      hyst_next = 1'b0;
  end

  assign hit = (mode_q == MODE_BINARY || mode_q == MODE_INVERTED) ? hyst_next : hit_strict;

  always_ff @(posedge CLK) begin
    if (!RST)
      hyst_q <= 1'b0;
    else if (adv && s1_valid)
      hyst_q <= hyst_next;
  end
`else
  logic unused_hyst;
  assign unused_hyst = ^{thresh_lo_q, s1_first_col};
  assign hit         = hit_strict;
`endif

  always_comb begin
    dec_data = '0;
    case (mode_q)
      MODE_BINARY:   dec_data = hit ? ONES : '0;
      MODE_INVERTED: dec_data = hit ? '0 : ONES;
      MODE_TO_ZERO:  dec_data = hit ? s1_data : '0;
      default:       dec_data = hit ? {CHANNELS{thresh_q}} : s1_data;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sof   <= 1'b0;
      m_eol   <= 1'b0;
    end else if (adv) begin
      m_valid <= s1_valid;
      m_data  <= dec_data;
      m_sof   <= s1_valid && s1_sof;
      m_eol   <= s1_valid && s1_eol;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_threshold_stream.sv
`default_nettype none
// Scoreboard bench for pixel_threshold_stream with a 4x2 frame, RGB 8-bit.
module tb_pixel_threshold_stream;

  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int NPIX = COLS * ROWS;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  cfg_mode = 2'd0;
  logic [7:0]  cfg_thresh = 8'd0;
  logic [7:0]  cfg_thresh_lo = 8'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [23:0] s_data = 24'd0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [23:0] m_data;
  logic        m_sof, m_eol, busy, frame_done;

  pixel_threshold_stream #(
    .PIX_W(8), .CHANNELS(3), .COLS(COLS), .ROWS(ROWS)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start), .cfg_mode(cfg_mode),
    .cfg_thresh(cfg_thresh), .cfg_thresh_lo(cfg_thresh_lo),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .busy(busy), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [23:0] data;
    logic        sof;
    logic        eol;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_pop_cyc = -1;
  bit          stall_en = 1'b0;
  logic [1:0]  f_mode;
  logic [7:0]  f_th, f_lo;
  logic        f_hyst;
  int          pix_idx;
  logic        prev_hold = 1'b0;
  logic [23:0] prev_data = 24'd0;
  logic [23:0] frame_a[NPIX];
  logic [23:0] frame_b[NPIX];

  always @(posedge CLK) cyc <= cyc + 1;

  initial forever begin
    @(posedge CLK);
    #1;
    m_ready = stall_en ? ~m_ready : 1'b1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] luma_of(input logic [23:0] p);
    int unsigned r, g, b, s;
    r = p & 24'hFF;
    g = (p >> 8) & 24'hFF;
    b = (p >> 16) & 24'hFF;
    s = 77 * r + 150 * g + 29 * b;
    return 8'(s / 256);
  endfunction

  task automatic push_expected(input logic [23:0] p);
    exp_t e;
    int col;
    logic [7:0] l;
    logic h;
    col = pix_idx % COLS;
    l = luma_of(p);
    h = (l > f_th);
`ifdef THRESH_HYST_EN
    if (f_mode == 2'd0 || f_mode == 2'd1) begin
      if (col == 0) f_hyst = 1'b0;
      if (l > f_th) f_hyst = 1'b1;
      else if (l < f_lo) f_hyst = 1'b0;
      h = f_hyst;
    end
`endif
    case (f_mode)
      2'd0: e.data = h ? 24'hFFFFFF : 24'h000000;
      2'd1: e.data = h ? 24'h000000 : 24'hFFFFFF;
      2'd2: e.data = h ? p : 24'h000000;
      default: e.data = h ? {f_th, f_th, f_th} : p;
    endcase
    e.sof = (pix_idx == 0);
    e.eol = (col == COLS - 1);
    sb.push_back(e);
    pix_idx++;
  endtask

  // Output monitor: pops on each output transfer and checks hold stability
  always @(negedge CLK) begin
    if (!RST) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", {31'd0, m_valid}, 32'd1);
        chk("hold_data", {8'd0, m_data}, {8'd0, prev_data});
      end
      if (m_valid && m_ready) begin
        chk("sb_nonempty", {31'd0, (sb.size() != 0)}, 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", {8'd0, m_data}, {8'd0, e.data});
          chk("out_sof", {31'd0, m_sof}, {31'd0, e.sof});
          chk("out_eol", {31'd0, m_eol}, {31'd0, e.eol});
        end
        last_pop_cyc = cyc;
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  task automatic send(input logic [23:0] p);
    int n;
    n = 0;
    s_data  = p;
    s_valid = 1'b1;
    @(negedge CLK);
    while (s_ready !== 1'b1 && n < 50) begin
      n++;
      @(negedge CLK);
    end
    chk("accept", {31'd0, s_ready}, 32'd1);
    if (s_ready === 1'b1) push_expected(p);
    @(posedge CLK);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic start_frame(input logic [1:0] mode, input logic [7:0] th, input logic [7:0] lo);
    cfg_mode      = mode;
    cfg_thresh    = th;
    cfg_thresh_lo = lo;
    start         = 1'b1;
    @(posedge CLK);
    #1;
    start   = 1'b0;
    f_mode  = mode;
    f_th    = th;
    f_lo    = lo;
    f_hyst  = 1'b0;
    pix_idx = 0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge CLK);
    while (frame_done !== 1'b1 && n < 60) begin
      n++;
      @(negedge CLK);
    end
    chk("frame_done", {31'd0, frame_done}, 32'd1);
    chk("done_latency", cyc, last_pop_cyc + 1);
    chk("sb_drained", sb.size(), 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    @(negedge CLK);
    chk("done_pulse", {31'd0, frame_done}, 32'd0);
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
    chk({tag, "_m_data"}, {8'd0, m_data}, 32'd0);
    chk({tag, "_m_sof"}, {31'd0, m_sof}, 32'd0);
    chk({tag, "_m_eol"}, {31'd0, m_eol}, 32'd0);
    chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
  endtask

  task automatic run_frame(input logic [1:0] mode, input logic [7:0] th, input logic [7:0] lo,
                           input bit use_b);
    start_frame(mode, th, lo);
    for (int i = 0; i < NPIX; i++) send(use_b ? frame_b[i] : frame_a[i]);
    wait_done();
  endtask

  initial begin
    frame_a[0] = {8'd50, 8'd50, 8'd50};
    frame_a[1] = {8'd30, 8'd30, 8'd30};
    frame_a[2] = {8'd50, 8'd50, 8'd50};
    frame_a[3] = {8'd0, 8'd0, 8'd255};
    frame_a[4] = {8'd255, 8'd0, 8'd0};
    frame_a[5] = {8'd41, 8'd41, 8'd41};
    frame_a[6] = {8'd40, 8'd40, 8'd40};
    frame_a[7] = {8'd200, 8'd200, 8'd200};

    frame_b[0] = {8'd200, 8'd200, 8'd200};
    frame_b[1] = {8'd20, 8'd20, 8'd20};
    frame_b[2] = {8'd100, 8'd100, 8'd100};
    frame_b[3] = {8'd101, 8'd101, 8'd101};
    for (int i = 4; i < NPIX; i++) frame_b[i] = 24'($urandom);

    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("init");
    RST = 1'b1;
    @(posedge CLK);
    #1;

    run_frame(2'd0, 8'd40, 8'd40, 1'b0);
    run_frame(2'd3, 8'd100, 8'd100, 1'b1);
    run_frame(2'd2, 8'd90, 8'd90, 1'b1);
    run_frame(2'd1, 8'd90, 8'd90, 1'b1);

    stall_en = 1'b1;
    run_frame(2'd0, 8'd40, 8'd40, 1'b0);
    stall_en = 1'b0;

    // Configuration and start changes during a frame must not take effect
    start_frame(2'd0, 8'd40, 8'd40);
    send(frame_a[0]);
    send(frame_a[1]);
    cfg_thresh = 8'd200;
    cfg_mode   = 2'd1;
    start      = 1'b1;
    for (int i = 2; i < NPIX; i++) send(frame_a[i]);
    start = 1'b0;
    wait_done();
    run_frame(2'd1, 8'd200, 8'd200, 1'b0);

    // Reset in the middle of a frame discards everything in flight
    start_frame(2'd0, 8'd40, 8'd40);
    send(frame_a[0]);
    send(frame_a[1]);
    send(frame_a[2]);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check_reset_outputs("midrst");
    RST = 1'b1;
    sb.delete();
    repeat (2) @(posedge CLK);
    #1;
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_s_ready", {31'd0, s_ready}, 32'd0);
    run_frame(2'd0, 8'd40, 8'd40, 1'b0);

`ifdef THRESH_HYST_EN
    frame_a[0] = {8'd120, 8'd120, 8'd120};
    frame_a[1] = {8'd80, 8'd80, 8'd80};
    frame_a[2] = {8'd40, 8'd40, 8'd40};
    frame_a[3] = {8'd80, 8'd80, 8'd80};
    frame_a[4] = {8'd80, 8'd80, 8'd80};
    frame_a[5] = {8'd120, 8'd120, 8'd120};
    frame_a[6] = {8'd60, 8'd60, 8'd60};
    frame_a[7] = {8'd40, 8'd40, 8'd40};
    run_frame(2'd0, 8'd100, 8'd50, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
